// File: rtl/filter_pad_stream.sv
// Zero-padding front end for the convolution filter: wraps a raw frame in
// B=(kernel_size-1)/2 zero rows/cols and appends flush_rows zero rows.
// Ports: clk, reset (async active-low), iStart, iValid/iData in,
//        oReady (comb), oValid/oData/oBusy/oDone (registered).
module filter_pad_stream #(
  parameter int unsigned width       = 1920,
  parameter int unsigned height      = 1080,
  parameter int unsigned kernel_size = 7,
  parameter int unsigned flush_rows  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iStart,
  input  logic        iValid,
  input  logic [23:0] iData,
  output logic        oReady,
  output logic        oValid,
  output logic [23:0] oData,
  output logic        oBusy,
  output logic        oDone
);

  localparam int unsigned B = (kernel_size - 1) / 2;

  localparam logic [15:0] PW_M1   = 16'(width + 2 * B - 1);
  localparam logic [15:0] PH_M1   = 16'(height + 2 * B - 1);
  localparam logic [15:0] FL_LAST = 16'(height + 2 * B + flush_rows - 1);
  localparam logic [15:0] R_LO    = 16'(B);
  localparam logic [15:0] R_HI    = 16'(B + height);
  localparam logic [15:0] C_LO    = 16'(B);
  localparam logic [15:0] C_HI    = 16'(B + width);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        valid_q, valid_d;
  logic [23:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic interior;
  logic ready;
  logic advance;

  always_comb begin
    interior = (row_q >= R_LO) && (row_q < R_HI)
            && (col_q >= C_LO) && (col_q < C_HI);
    ready    = (state_q == RUN) && interior;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        col_d = '0;
        row_d = '0;
        if (iStart) state_d = RUN;
      end
      RUN:   advance = interior ? iValid : 1'b1;
      FLUSH: advance = 1'b1;
      DONE: begin
        col_d   = '0;
        row_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (col_q == PW_M1) begin
        col_d = '0;
        row_d = row_q + 16'd1;
        if (state_q == RUN && row_q == PH_M1)
          state_d = (flush_rows == 0) ? DONE : FLUSH;
        if (state_q == FLUSH && row_q == FL_LAST)
          state_d = DONE;
      end else begin
        col_d = col_q + 16'd1;
      end
    end

    valid_d = advance;
    data_d  = data_q;
    if (advance) data_d = ready ? iData : 24'h0;

    // busy drops on the same edge that raises done
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oReady = ready;
  assign oValid = valid_q;
  assign oData  = data_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;

endmodule
